// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by a 64-bit word array; independent read and write channels, one burst each.
// Optional address range checking is enabled by defining AXI_MEM_SLAVE_RANGE_CHK_EN.
module axi_mem_slave #(
  parameter int          IDW  = 12,
  parameter int          MAW  = 10,
  parameter logic [31:0] BASE = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           reset,

  input  logic [IDW-1:0] s_axi_awid,
  input  logic [31:0]    s_axi_awaddr,
  input  logic [7:0]     s_axi_awlen,
  input  logic [2:0]     s_axi_awsize,
  input  logic [1:0]     s_axi_awburst,
  input  logic           s_axi_awlock,
  input  logic [3:0]     s_axi_awcache,
  input  logic [2:0]     s_axi_awprot,
  input  logic [3:0]     s_axi_awqos,
  input  logic           s_axi_awvalid,
  output logic           s_axi_awready,

  input  logic [63:0]    s_axi_wdata,
  input  logic [7:0]     s_axi_wstrb,
  input  logic           s_axi_wlast,
  input  logic           s_axi_wvalid,
  output logic           s_axi_wready,

  output logic [IDW-1:0] s_axi_bid,
  output logic [1:0]     s_axi_bresp,
  output logic           s_axi_bvalid,
  input  logic           s_axi_bready,

  input  logic [IDW-1:0] s_axi_arid,
  input  logic [31:0]    s_axi_araddr,
  input  logic [7:0]     s_axi_arlen,
  input  logic [2:0]     s_axi_arsize,
  input  logic [1:0]     s_axi_arburst,
  input  logic           s_axi_arlock,
  input  logic [3:0]     s_axi_arcache,
  input  logic [2:0]     s_axi_arprot,
  input  logic [3:0]     s_axi_arqos,
  input  logic           s_axi_arvalid,
  output logic           s_axi_arready,

  output logic [IDW-1:0] s_axi_rid,
  output logic [63:0]    s_axi_rdata,
  output logic [1:0]     s_axi_rresp,
  output logic           s_axi_rlast,
  output logic           s_axi_rvalid,
  input  logic           s_axi_rready
);

  localparam int DEPTH = 1 << MAW;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  logic [63:0] mem [DEPTH];

  // Beat-to-beat address step for FIXED / INCR / WRAP; illegal WRAP lengths fall back to INCR.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] step;
    logic [31:0] bnd;
    step = 32'd1 << size;
    bnd  = ({24'd0, len} + 32'd1) << size;
    next_addr = a + step;
    if (burst == 2'b00)
      next_addr = a;
    else if (burst == 2'b10 &&
             (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (a & ~(bnd - 32'd1)) | ((a + step) & (bnd - 32'd1));
  endfunction

  // ---------------- write channel ----------------
  w_state_t       w_state, w_state_n;
  logic [IDW-1:0] w_id;
  logic [31:0]    w_addr;
  logic [7:0]     w_len, w_cnt;
  logic [2:0]     w_size;
  logic [1:0]     w_burst;
  logic           w_err;
  logic [1:0]     b_resp;
  logic           aw_hs, w_hs, w_last, w_oor;
  logic [32:0]    w_diff;
  logic [MAW-1:0] w_idx;

  assign aw_hs  = s_axi_awvalid & s_axi_awready;
  assign w_hs   = s_axi_wvalid & s_axi_wready;
  assign w_last = (w_cnt == w_len);
  assign w_diff = {1'b0, w_addr} - {1'b0, BASE};
  assign w_idx  = w_diff[MAW+2:3];

  always_comb begin
    w_state_n     = w_state;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi_awready = !reset;
        if (s_axi_awvalid) w_state_n = W_DATA;
      end
      W_DATA: begin
        s_axi_wready = !reset;
        if (s_axi_wvalid && w_last) w_state_n = W_RESP;
      end
      W_RESP: begin
        s_axi_bvalid = !reset;
        if (s_axi_bready) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
      b_resp  <= 2'b00;
    end else begin
      if (aw_hs) begin
        w_id    <= s_axi_awid;
        w_addr  <= s_axi_awaddr;
        w_len   <= s_axi_awlen;
        w_size  <= s_axi_awsize;
        w_burst <= s_axi_awburst;
        w_cnt   <= '0;
        w_err   <= 1'b0;
      end
      if (w_hs) begin
        w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
        w_cnt  <= w_cnt + 8'd1;
        if (w_oor) w_err <= 1'b1;
        if (w_last) b_resp <= (w_err | w_oor) ? 2'b10 : 2'b00;
      end
    end
  end

  // Array is never reset so contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (w_hs && !w_oor) begin
      for (int i = 0; i < 8; i++)
        if (s_axi_wstrb[i]) mem[w_idx][8*i +: 8] <= s_axi_wdata[8*i +: 8];
    end
  end

  assign s_axi_bid   = w_id;
  assign s_axi_bresp = b_resp;

  // ---------------- read channel ----------------
  r_state_t       r_state, r_state_n;
  logic [IDW-1:0] r_id;
  logic [31:0]    r_addr, r_nxt, ld_addr;
  logic [7:0]     r_len, r_cnt;
  logic [2:0]     r_size;
  logic [1:0]     r_burst;
  logic [63:0]    r_data;
  logic [1:0]     r_resp;
  logic           r_last;
  logic           ar_hs, r_hs, r_load, ld_oor;
  logic [32:0]    ld_diff;
  logic [MAW-1:0] ld_idx;

  assign ar_hs   = s_axi_arvalid & s_axi_arready;
  assign r_hs    = s_axi_rvalid & s_axi_rready;
  assign r_nxt   = next_addr(r_addr, r_len, r_size, r_burst);
  assign ld_addr = ar_hs ? s_axi_araddr : r_nxt;
  assign ld_diff = {1'b0, ld_addr} - {1'b0, BASE};
  assign ld_idx  = ld_diff[MAW+2:3];
  assign r_load  = ar_hs | (r_hs & !r_last);

  always_comb begin
    r_state_n     = r_state;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi_arready = !reset;
        if (s_axi_arvalid) r_state_n = R_DATA;
      end
      R_DATA: begin
        s_axi_rvalid = !reset;
        if (s_axi_rready && r_last) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_state_n;
  end

  // The array read sits on the same edge as any write, so a colliding read sees old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_last  <= 1'b0;
      r_data  <= '0;
      r_resp  <= 2'b00;
    end else begin
      if (ar_hs) begin
        r_id    <= s_axi_arid;
        r_addr  <= s_axi_araddr;
        r_len   <= s_axi_arlen;
        r_size  <= s_axi_arsize;
        r_burst <= s_axi_arburst;
        r_cnt   <= '0;
        r_last  <= (s_axi_arlen == 8'd0);
      end else if (r_hs) begin
        if (r_last) begin
          r_last <= 1'b0;
        end else begin
          r_addr <= r_nxt;
          r_cnt  <= r_cnt + 8'd1;
          r_last <= (r_cnt + 8'd1 == r_len);
        end
      end
      if (r_load) begin
        r_data <= ld_oor ? 64'd0 : mem[ld_idx];
        r_resp <= ld_oor ? 2'b10 : 2'b00;
      end
    end
  end

  assign s_axi_rid   = r_id;
  assign s_axi_rdata = r_data;
  assign s_axi_rresp = r_resp;
  assign s_axi_rlast = r_last;

  // ---------------- range check ----------------
`ifdef AXI_MEM_SLAVE_RANGE_CHK_EN
  localparam logic [32:0] SPAN = 33'd8 << MAW;
  // A borrow out of the subtraction sets bit 32, which also lands above SPAN.
  assign w_oor  = (w_diff >= SPAN);
  assign ld_oor = (ld_diff >= SPAN);
`else
  assign w_oor  = 1'b0;
  assign ld_oor = 1'b0;
`endif

  logic unused;
  assign unused = ^{s_axi_awlock, s_axi_awcache, s_axi_awprot, s_axi_awqos,
                    s_axi_arlock, s_axi_arcache, s_axi_arprot, s_axi_arqos,
                    s_axi_wlast, w_diff[2:0], w_diff[32:MAW+3],
                    ld_diff[2:0], ld_diff[32:MAW+3]};

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: stimulus pushes expected B/R responses, a negedge monitor checks them.
// Test 6 expectations follow AXI_MEM_SLAVE_RANGE_CHK_EN.
module tb_axi_mem_slave;
  localparam int IDW = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [IDW-1:0] s_axi_awid, s_axi_arid, s_axi_bid, s_axi_rid;
  logic [31:0]    s_axi_awaddr, s_axi_araddr;
  logic [7:0]     s_axi_awlen, s_axi_arlen, s_axi_wstrb;
  logic [2:0]     s_axi_awsize, s_axi_arsize;
  logic [1:0]     s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic           s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic           s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic           s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [63:0]    s_axi_wdata, s_axi_rdata;

  axi_mem_slave #(.IDW(IDW), .MAW(10), .BASE(32'h0000_0000)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awid(s_axi_awid), .s_axi_awaddr(s_axi_awaddr), .s_axi_awlen(s_axi_awlen),
    .s_axi_awsize(s_axi_awsize), .s_axi_awburst(s_axi_awburst), .s_axi_awlock(1'b0),
    .s_axi_awcache(4'd0), .s_axi_awprot(3'd0), .s_axi_awqos(4'd0),
    .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
    .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb), .s_axi_wlast(s_axi_wlast),
    .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
    .s_axi_bid(s_axi_bid), .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid),
    .s_axi_bready(s_axi_bready),
    .s_axi_arid(s_axi_arid), .s_axi_araddr(s_axi_araddr), .s_axi_arlen(s_axi_arlen),
    .s_axi_arsize(s_axi_arsize), .s_axi_arburst(s_axi_arburst), .s_axi_arlock(1'b0),
    .s_axi_arcache(4'd0), .s_axi_arprot(3'd0), .s_axi_arqos(4'd0),
    .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
    .s_axi_rid(s_axi_rid), .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
    .s_axi_rlast(s_axi_rlast), .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready)
  );

  typedef struct { logic [IDW-1:0] id; logic [1:0] resp; } b_exp_t;
  typedef struct { logic [IDW-1:0] id; logic [63:0] data; logic last; logic [1:0] resp; } r_exp_t;

  b_exp_t bq[$];
  r_exp_t rq[$];
  b_exp_t be;
  r_exp_t re;

  int n_checks = 0;
  int n_fail   = 0;
  logic toggle_rr = 1'b0;

  logic [63:0] wd [16];
  logic [7:0]  ws [16];
  logic [63:0] rd [16];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s: event not as expected", name);
  endtask

  // Scoreboard monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (s_axi_bvalid && s_axi_bready) begin
      if (bq.size() == 0) reportFail("b_unexpected");
      else begin
        be = bq.pop_front();
        checkOutput("bid", 64'(s_axi_bid), 64'(be.id));
        checkOutput("bresp", 64'(s_axi_bresp), 64'(be.resp));
      end
    end
    if (s_axi_rvalid) begin
      if (rq.size() == 0) reportFail("r_unexpected");
      else if (s_axi_rready) begin
        re = rq.pop_front();
        checkOutput("rid", 64'(s_axi_rid), 64'(re.id));
        checkOutput("rdata", s_axi_rdata, re.data);
        checkOutput("rlast", 64'(s_axi_rlast), 64'(re.last));
        checkOutput("rresp", 64'(s_axi_rresp), 64'(re.resp));
      end else begin
        checkOutput("rdata_stall", s_axi_rdata, rq[0].data);
        checkOutput("rlast_stall", 64'(s_axi_rlast), 64'(rq[0].last));
      end
    end
  end

  function automatic logic rdy(input int ch);
    case (ch)
      0:       return s_axi_awready;
      1:       return s_axi_wready;
      default: return s_axi_arready;
    endcase
  endfunction

  task automatic waitReady(input int ch, input string name);
    int n = 0;
    @(negedge clk);
    while (!rdy(ch) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!rdy(ch)) reportFail(name);
    @(posedge clk);
    #1;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((bq.size() != 0 || rq.size() != 0) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
      if (toggle_rr) s_axi_rready = ~s_axi_rready;
    end
    if (bq.size() != 0 || rq.size() != 0) begin
      reportFail("drain_timeout");
      bq.delete();
      rq.delete();
    end
  endtask

  task automatic axiWrite(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                          input logic [1:0] burst, input logic [1:0] exp_resp);
    b_exp_t e;
    e.id = id;
    e.resp = exp_resp;
    bq.push_back(e);
    @(posedge clk);
    #1;
    s_axi_awid = id; s_axi_awaddr = addr; s_axi_awlen = 8'(len);
    s_axi_awsize = 3'd3; s_axi_awburst = burst; s_axi_awvalid = 1'b1;
    waitReady(0, "awready_timeout");
    s_axi_awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = ws[i]; s_axi_wlast = (i == len); s_axi_wvalid = 1'b1;
      waitReady(1, "wready_timeout");
    end
    s_axi_wvalid = 1'b0;
    s_axi_wlast  = 1'b0;
    waitDrain();
  endtask

  task automatic startRead(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                           input logic [1:0] burst);
    @(posedge clk);
    #1;
    s_axi_arid = id; s_axi_araddr = addr; s_axi_arlen = 8'(len);
    s_axi_arsize = 3'd3; s_axi_arburst = burst; s_axi_arvalid = 1'b1;
    waitReady(2, "arready_timeout");
    s_axi_arvalid = 1'b0;
  endtask

  task automatic axiRead(input logic [IDW-1:0] id, input logic [31:0] addr, input int len,
                         input logic [1:0] burst, input logic [1:0] exp_resp, input logic toggle);
    r_exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id = id; e.data = rd[i]; e.last = (i == len); e.resp = exp_resp;
      rq.push_back(e);
    end
    startRead(id, addr, len, burst);
    s_axi_rready = 1'b1;
    toggle_rr = toggle;
    waitDrain();
    toggle_rr = 1'b0;
    s_axi_rready = 1'b1;
  endtask

  task automatic applyStimulus();
    r_exp_t e;
    // Reset state
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", 64'(s_axi_awready), 64'd0);
    checkOutput("rst_arready", 64'(s_axi_arready), 64'd0);
    checkOutput("rst_wready", 64'(s_axi_wready), 64'd0);
    checkOutput("rst_bvalid", 64'(s_axi_bvalid), 64'd0);
    checkOutput("rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("rst_bid_bresp", 64'({s_axi_bid, s_axi_bresp}), 64'd0);
    checkOutput("rst_rid_rresp_rlast", 64'({s_axi_rid, s_axi_rresp, s_axi_rlast}), 64'd0);
    checkOutput("rst_rdata", s_axi_rdata, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_awready", 64'(s_axi_awready), 64'd1);
    checkOutput("post_rst_arready", 64'(s_axi_arready), 64'd1);

    // 1: single beat write/read
    wd[0] = 64'h1122334455667788; ws[0] = 8'hFF;
    axiWrite(12'h0A1, 32'h0, 0, 2'b01, 2'b00);
    rd[0] = 64'h1122334455667788;
    axiRead(12'h0B2, 32'h0, 0, 2'b01, 2'b00, 1'b0);

    // 2: partial strobe
    wd[0] = '1; ws[0] = 8'hFF;
    axiWrite(12'h003, 32'h0, 0, 2'b01, 2'b00);
    wd[0] = 64'h0; ws[0] = 8'h0F;
    axiWrite(12'h004, 32'h0, 0, 2'b01, 2'b00);
    rd[0] = 64'hFFFFFFFF00000000;
    axiRead(12'h005, 32'h0, 0, 2'b01, 2'b00, 1'b0);

    // 3: INCR burst with rready toggling
    for (int i = 0; i < 4; i++) begin wd[i] = 64'hA0 + 64'(i); ws[i] = 8'hFF; rd[i] = 64'hA0 + 64'(i); end
    axiWrite(12'h010, 32'h40, 3, 2'b01, 2'b00);
    axiRead(12'h011, 32'h40, 3, 2'b01, 2'b00, 1'b1);

    // 4: WRAP read starting mid-block
    for (int i = 0; i < 4; i++) begin wd[i] = 64'(i); ws[i] = 8'hFF; end
    axiWrite(12'h020, 32'h0, 3, 2'b01, 2'b00);
    rd[0] = 64'd3; rd[1] = 64'd0; rd[2] = 64'd1; rd[3] = 64'd2;
    axiRead(12'h021, 32'h18, 3, 2'b10, 2'b00, 1'b0);

    // FIXED burst: both beats hit one word, second with upper strobes only
    wd[0] = 64'h1111111111111111; ws[0] = 8'hFF;
    wd[1] = 64'h2222222222222222; ws[1] = 8'hF0;
    axiWrite(12'h030, 32'h80, 1, 2'b00, 2'b00);
    rd[0] = 64'h2222222211111111; rd[1] = 64'h2222222211111111;
    axiRead(12'h031, 32'h80, 1, 2'b00, 2'b00, 1'b0);

    // 5: reset pulse during beat 2 of a len7 read
    e.id = 12'h040; e.data = 64'd0; e.last = 1'b0; e.resp = 2'b00;
    rq.push_back(e);
    s_axi_rready = 1'b1;
    startRead(12'h040, 32'h0, 7, 2'b01);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_rvalid", 64'(s_axi_rvalid), 64'd0);
    checkOutput("mid_rst_arready", 64'(s_axi_arready), 64'd1);
    checkOutput("mid_rst_beats_seen", 64'(rq.size()), 64'd0);
    rq.delete();
    rd[0] = 64'd1; rd[1] = 64'd2;
    axiRead(12'h041, 32'h8, 1, 2'b01, 2'b00, 1'b0);

    // 6: write just past the end of the array
    wd[0] = 64'hDEADBEEF00006666; ws[0] = 8'hFF;
`ifdef AXI_MEM_SLAVE_RANGE_CHK_EN
    axiWrite(12'h050, 32'h2000, 0, 2'b01, 2'b10);
    rd[0] = 64'd0;
    axiRead(12'h051, 32'h0, 0, 2'b01, 2'b00, 1'b0);
    rd[0] = 64'd0;
    axiRead(12'h052, 32'h2000, 0, 2'b01, 2'b10, 1'b0);
`else
    axiWrite(12'h050, 32'h2000, 0, 2'b01, 2'b00);
    rd[0] = 64'hDEADBEEF00006666;
    axiRead(12'h051, 32'h0, 0, 2'b01, 2'b00, 1'b0);
    axiRead(12'h052, 32'h2000, 0, 2'b01, 2'b00, 1'b0);
`endif
    repeat (5) @(posedge clk);
  endtask

  initial begin
    s_axi_awid = '0; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = '0; s_axi_awburst = '0;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_arid = '0; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = '0; s_axi_arburst = '0;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    reset = 1'b1;
    $display("[TB] starting axi_mem_slave bench");
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    reportFail("watchdog");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
